// File: rtl/cover_pkg.sv
// cover_pkg: shared widths for the toggle cover scheduler
package cover_pkg;
    localparam int INDEX_W = 64;
    localparam int COUNT_W = 16;
endpackage

// File: rtl/cover_rr_pick.sv
// cover_rr_pick: round-robin picker, lowest request strictly above ptr, wrapping to bit 0
module cover_rr_pick #(
    parameter int WIDTH = 44,
    parameter int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             grant_valid,
    output logic [PW-1:0]    grant_index
);
    logic          hi_found;
    logic [PW-1:0] hi_idx, lo_idx;
    // descending scan so the last hit written is the lowest index
    always_comb begin
        hi_found = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = PW'(i);
                if (i > int'(ptr)) begin
                    hi_idx = PW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        grant_valid = |req;
        grant_index = hi_found ? hi_idx : lo_idx;
    end
endmodule

// File: rtl/cover_toggle_sched.sv
// cover_toggle_sched: toggle cover hit scheduler, one report slot; COVER_TOGGLE_DEDUP_EN adds a per-epoch seen mask
module cover_toggle_sched
    import cover_pkg::*;
#(
    parameter int WIDTH = 44,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 10906
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   valid,
    input  logic               clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INDEX_W-1:0] out_index,
    output logic               busy,
    output logic [COUNT_W-1:0] merged_count
);
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_check
        $error("cover_toggle_sched: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end

    logic [WIDTH-1:0]   pending, acc, req, gmask, merge_bits, pend_n;
    logic [PW-1:0]      ptr, gidx;
    logic               gv, load, take;
    logic [COUNT_W:0]   pop, sum;

`ifdef COVER_TOGGLE_DEDUP_EN
    logic [WIDTH-1:0] seen;
    assign acc = clear ? '0 : valid & ~seen;
`else
    assign acc = clear ? '0 : valid;
`endif

    assign load = !out_valid || out_ready;
    assign req = pending | acc;
    assign take = load && gv && !clear;
    assign gmask = take ? ({{(WIDTH-1){1'b0}}, 1'b1} << gidx) : '0;
    assign merge_bits = acc & pending & ~gmask;
    assign busy = (|pending) || out_valid;

    cover_rr_pick #(.WIDTH(WIDTH), .PW(PW)) u_pick (
        .req(req),
        .ptr(ptr),
        .grant_valid(gv),
        .grant_index(gidx)
    );

    // next pending set (granted bit survives only if it was pending and hit again) and merge popcount
    always_comb begin
        pend_n = (req & ~gmask) | (acc & pending & gmask);
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + (COUNT_W+1)'(merge_bits[i]);
        sum = {1'b0, merged_count} + pop;
    end

    // state update: reset over clear over normal scheduling
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            merged_count <= '0;
            ptr <= PW'(WIDTH - 1);
`ifdef COVER_TOGGLE_DEDUP_EN
            seen <= '0;
`endif
        end else if (clear) begin
            pending <= '0;
            merged_count <= '0;
            out_valid <= out_valid && !out_ready;
`ifdef COVER_TOGGLE_DEDUP_EN
            seen <= '0;
`endif
        end else begin
            pending <= pend_n;
            merged_count <= sum[COUNT_W] ? '1 : sum[COUNT_W-1:0];
            if (load) out_valid <= gv;
            if (take) begin
                out_index <= INDEX_W'(COVER_INDEX) + INDEX_W'(gidx);
                ptr <= gidx;
            end
`ifdef COVER_TOGGLE_DEDUP_EN
            seen <= seen | gmask;
`endif
        end
    end
endmodule

// File: tb/tb_cover_toggle_sched.sv
// tb_cover_toggle_sched: directed self-checking bench for cover_toggle_sched (honours COVER_TOGGLE_DEDUP_EN)
module tb_cover_toggle_sched;
    localparam int W = 44;
    localparam int CI = 100;
`ifdef COVER_TOGGLE_DEDUP_EN
    localparam bit DD = 1'b1;
`else
    localparam bit DD = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset, clear, out_ready, out_valid, busy;
    logic [W-1:0]  valid;
    logic [63:0]   out_index;
    logic [15:0]   merged_count;
    int            vectors = 0;
    int            errors = 0;
    int            cnt;

    cover_toggle_sched #(.WIDTH(W), .COVER_INDEX(CI), .COVER_TOTAL(10906)) dut (
        .clock(clock),
        .reset(reset),
        .valid(valid),
        .clear(clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_index(out_index),
        .busy(busy),
        .merged_count(merged_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid = '0;
        clear = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        out_ready = 1'b0;
        do_reset();
        step();
        chk("rst_ov", 64'(out_valid), 0);
        chk("rst_idx", out_index, 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_mc", 64'(merged_count), 0);

        // single hit, 1-cycle latency, then idle
        out_ready = 1'b1;
        valid = 44'h1;
        step();
        valid = '0;
        chk("one_ov", 64'(out_valid), 1);
        chk("one_idx", out_index, CI);
        step();
        chk("one_idle_ov", 64'(out_valid), 0);
        chk("one_idle_busy", 64'(busy), 0);

        // all bits at once: 44 back-to-back reports 0..43
        do_reset();
        out_ready = 1'b1;
        valid = '1;
        step();
        valid = '0;
        for (int k = 0; k < W; k++) begin
            chk($sformatf("all_ov%0d", k), 64'(out_valid), 1);
            chk($sformatf("all_idx%0d", k), out_index, 64'(CI + k));
            step();
        end
        chk("all_end_ov", 64'(out_valid), 0);
        chk("all_mc", 64'(merged_count), 0);

        // backpressure with repeated hits on bit 5
        do_reset();
        out_ready = 1'b0;
        valid = 44'h20;
        step();
        chk("bp_ov1", 64'(out_valid), 1);
        chk("bp_idx1", out_index, CI + 5);
        step();
        chk("bp_idx2", out_index, CI + 5);
        chk("bp_mc2", 64'(merged_count), 0);
        step();
        valid = '0;
        chk("bp_idx3", out_index, CI + 5);
        chk("bp_mc3", 64'(merged_count), DD ? 0 : 1);
        step();
        chk("bp_hold_ov", 64'(out_valid), 1);
        chk("bp_hold_idx", out_index, CI + 5);
        out_ready = 1'b1;
        step();
        chk("bp_rel_ov", 64'(out_valid), DD ? 0 : 1);
        chk("bp_rel_idx", out_index, CI + 5);
        step();
        chk("bp_end_ov", 64'(out_valid), 0);

        // bit 7 hit at cycles 0 and 10, then a clear epoch and one more hit
        do_reset();
        out_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            valid = (c == 0 || c == 10) ? 44'h80 : 44'h0;
            step();
            if (out_valid && out_index == 64'(CI + 7)) cnt++;
        end
        valid = '0;
        chk("dd_count", 64'(cnt), DD ? 1 : 2);
        clear = 1'b1;
        step();
        clear = 1'b0;
        valid = 44'h80;
        step();
        valid = '0;
        chk("dd_epoch_ov", 64'(out_valid), 1);
        chk("dd_epoch_idx", out_index, CI + 7);
        step();
        chk("dd_epoch_end", 64'(out_valid), 0);

        // clear coincident with hits on bits 0/1 and an occupied slot
        do_reset();
        out_ready = 1'b0;
        valid = 44'h200;
        step();
        step();
        step();
        chk("clr_pre_mc", 64'(merged_count), DD ? 0 : 1);
        valid = 44'h3;
        clear = 1'b1;
        step();
        clear = 1'b0;
        valid = '0;
        chk("clr_ov", 64'(out_valid), 1);
        chk("clr_idx", out_index, CI + 9);
        chk("clr_mc", 64'(merged_count), 0);
        chk("clr_busy", 64'(busy), 1);
        out_ready = 1'b1;
        step();
        chk("clr_drain_ov", 64'(out_valid), 0);
        chk("clr_drain_busy", 64'(busy), 0);
        step();
        chk("clr_after_ov", 64'(out_valid), 0);

        // merge counter saturation, then reset mid-stream
        do_reset();
        out_ready = 1'b0;
        valid = '1;
        step();
        chk("sat_ov", 64'(out_valid), 1);
        chk("sat_idx", out_index, CI);
        step();
        chk("sat_mc43", 64'(merged_count), 43);
        repeat (1600) step();
        chk("sat_mc_max", 64'(merged_count), 16'hFFFF);
        step();
        chk("sat_mc_hold", 64'(merged_count), 16'hFFFF);
        reset = 1'b1;
        step();
        chk("mid_rst_ov", 64'(out_valid), 0);
        chk("mid_rst_idx", out_index, 0);
        chk("mid_rst_mc", 64'(merged_count), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        reset = 1'b0;
        valid = '0;
        step();
        chk("post_rst_ov", 64'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/cover_toggle_sched.md
COVER_TOGGLE_SCHED -- requirements
Module: cover_toggle_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 44, number of toggle cover points handled.
REQ-002 SHALL have parameter COVER_INDEX, default 0, global index of bit 0.
REQ-003 SHALL have parameter COVER_TOTAL, default 10906, total cover points; COVER_INDEX+WIDTH <= COVER_TOTAL is checked at elaboration.
REQ-004 SHALL have port clock, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port valid, input, WIDTH, per-point hit strobes, sampled every cycle.
REQ-007 SHALL have port clear, input, 1, single-cycle epoch clear.
REQ-008 SHALL have port out_valid, output, 1, report available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts report.
REQ-010 SHALL have port out_index, output, 64, global cover index (COVER_INDEX + bit).
REQ-011 SHALL have port busy, output, 1, high when any pending bit or out_valid.
REQ-012 SHALL have port merged_count, output, 16, saturating count of merged hits.

Function
REQ-013 SHALL hold a WIDTH-bit pending register; accepted hit = valid bit (masked per REQ-026) sets its pending bit.
REQ-014 SHALL hold a single registered output slot (out_valid/out_index); slot loads when empty or when out_valid&&out_ready in the same cycle.
REQ-015 SHALL select the loaded bit round-robin: lowest pending bit strictly above last granted bit, wrapping to bit 0; pointer resets to WIDTH-1 so first grant scans from bit 0.
REQ-016 SHALL clear the granted pending bit on load; a same-cycle hit on the granted bit re-sets it.
REQ-017 SHALL give latency of exactly 1 cycle: hit at cycle t with empty slot and no other pending -> out_valid at t+1.
REQ-018 SHALL keep out_valid and out_index stable while out_valid && !out_ready.
REQ-019 SHALL sustain one report per cycle while out_ready is held high and bits are pending.
REQ-020 SHALL, for a hit on a bit already pending (and not granted that cycle), merge it and add the number of such bits (popcount) to merged_count, saturating at 0xFFFF.
REQ-021 SHALL, on clear, zero pending, the dedup mask and merged_count next cycle; same-cycle valid bits are dropped; an occupied output slot is retained until accepted.
REQ-022 SHALL treat valid == 0 with empty pending as idle: out_valid low, busy low, no state change.

Reset
REQ-023 SHALL on reset set pending=0, out_valid=0, out_index=0, merged_count=0, dedup mask=0, pointer=WIDTH-1, busy=0.
REQ-024 SHALL let reset take priority over clear, valid and out_ready; an in-flight report is discarded.
REQ-025 SHALL ignore valid during the reset cycle.

Configuration
REQ-026 SHALL with COVER_TOGGLE_DEDUP_EN defined keep a WIDTH-bit seen mask set on grant, and mask valid with ~seen so each point reports at most once per epoch (clear/reset).
REQ-027 SHALL without COVER_TOGGLE_DEDUP_EN omit the seen mask; every non-merged hit produces a report.

Structure
REQ-028 SHALL place the 64-bit index width and 16-bit counter width constants in shared package cover_pkg.
REQ-029 SHALL implement the round-robin selection in one sub-module cover_rr_pick (inputs request vector, pointer; outputs grant_valid, grant index).

Verification
REQ-030 SHALL cover: valid=44'h1 one cycle, out_ready=1 -> out_valid next cycle, out_index=COVER_INDEX+0, then idle.
REQ-031 SHALL cover: valid=all-ones one cycle, out_ready=1 -> 44 reports indices 0..43 on 44 consecutive cycles, merged_count=0.
REQ-032 SHALL cover: out_ready=0, bit 5 hit 3 cycles -> one report held stable, merged_count=1 (1st sets pending→slot, 2nd pending, 3rd merges), then index 5 twice after release (no dedup).
REQ-033 SHALL cover: COVER_TOGGLE_DEDUP_EN defined, bit 7 hit at cycles 0 and 10 -> exactly one report; after clear, bit 7 hit -> one more report.
REQ-034 SHALL cover: clear coincident with valid=44'h3 and occupied slot -> slot drains, no reports for bits 0/1, merged_count=0.
REQ-035 SHALL cover: merged_count at 0xFFFF plus further merges -> stays 0xFFFF; reset mid-stream -> all outputs zero next cycle.
